// File: rtl/microcode_pkg.sv
// ============================================================================
//  Module      : microcode_pkg
//  Description : Shared micro-op types and constants for the Thumb microcode
//                sequencer: uop layout, functional-unit codes, register
//                indices, sequencer states and the SP-adjust uop builder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package microcode_pkg;

   // Functional-unit selector carried in every uop
   typedef enum logic [2:0] {
      FU_MOV   = 3'd0,
      FU_ADD   = 3'd1,
      FU_LOGIC = 3'd2,
      FU_MEM   = 3'd3,
      FU_BR    = 3'd4,
      FU_TRAP  = 3'd7
   } fu_e;

   // 18-bit uop, MSB first: WE, OP, FU, FLAGS, DEST, S1, IMM/S2
   typedef struct packed {
      logic       we;
      logic [2:0] op;
      fu_e        fu;
      logic [3:0] flags;
      logic [1:0] dest;
      logic [1:0] s1;
      logic [2:0] imm;
   } uop_t;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ISSUE  = 2'd1,
      S_EXPAND = 2'd2
   } seq_state_e;

   // Architectural register indices reported on uop_reg_o
   localparam logic [3:0] REG_SP = 4'd13;
   localparam logic [3:0] REG_LR = 4'd14;
   localparam logic [3:0] REG_PC = 4'd15;

   // The 2-bit DEST/S1 fields cannot name SP; code 3 denotes the stack pointer
   localparam logic [1:0] DEST_SP = 2'd3;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_LDR = 3'b000;
   localparam logic [2:0] OP_STR = 3'b001;
   localparam logic [2:0] OP_BX  = 3'b011;

   localparam uop_t UOP_NOOP = '0;

   // SP adjust by 4*words; the word count spans {S1,IMM} since SP is implied
   function automatic uop_t sp_adjust_uop(input logic sub, input logic [4:0] words);
      uop_t u;
      u       = UOP_NOOP;
      u.we    = 1'b1;
      u.op    = sub ? OP_SUB : OP_ADD;
      u.fu    = FU_ADD;
      u.dest  = DEST_SP;
      {u.s1, u.imm} = words;
      return u;
   endfunction

endpackage

`default_nettype wire

// File: rtl/microcode_sequencer_decode.sv
// ============================================================================
//  Module      : uop_decode_table
//  Description : Combinational Thumb instruction to single-uop lookup with
//                PUSH/POP detection.
//                Config macro MICROCODE_SEQ_ILLEGAL_EN: when defined, unmatched
//                encodings decode to a trap uop and raise illegal.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uop_decode_table
   import microcode_pkg::*;
#(
   parameter int INSTR_WIDTH_P = 16
) (
   input  logic [INSTR_WIDTH_P-1:0] instr,
   output uop_t                     uop,
   output logic                     is_push,
   output logic                     is_pop,
   output logic                     illegal
);

   assign is_push = (instr[15:9] == 7'b1011010);
   assign is_pop  = (instr[15:9] == 7'b1011110);

   logic w_matched;

   // Table lookup; PUSH/POP match here but their uops come from the sequencer
   always_comb begin
      uop       = UOP_NOOP;
      w_matched = 1'b1;
      illegal   = 1'b0;
      if (instr[15:11] == 5'b00011) begin
         // ADDS/SUBS register or imm3
         uop.we    = 1'b1;
         uop.op    = {2'b00, instr[9]};
         uop.fu    = FU_ADD;
         uop.flags = 4'b1111;
         uop.dest  = instr[1:0];
         uop.s1    = instr[4:3];
         uop.imm   = instr[8:6];
      end else if (instr[15:13] == 3'b001) begin
         // MOVS/CMP/ADDS/SUBS imm8; CMP writes no register
         uop.we    = (instr[12:11] != 2'b01);
         uop.op    = {1'b0, instr[12:11]};
         uop.fu    = (instr[12:11] == 2'b00) ? FU_MOV : FU_ADD;
         uop.flags = 4'b1111;
         uop.dest  = instr[9:8];
         uop.s1    = instr[9:8];
         uop.imm   = instr[2:0];
      end else if (instr[15:10] == 6'b010000) begin
         // Data-processing register ops (ANDS, EORS, ...)
         uop.we    = 1'b1;
         uop.op    = instr[8:6];
         uop.fu    = FU_LOGIC;
         uop.flags = 4'b1100;
         uop.dest  = instr[1:0];
         uop.s1    = instr[1:0];
         uop.imm   = instr[5:3];
      end else if (instr[15:7] == 9'b010001110) begin
         // BX Rm
         uop.op    = OP_BX;
         uop.fu    = FU_BR;
         uop.s1    = instr[4:3];
         uop.imm   = instr[5:3];
      end else if (instr[15:8] == 8'b10110000) begin
         // ADD/SUB SP, #imm7
         uop.we    = 1'b1;
         uop.op    = {2'b00, instr[7]};
         uop.fu    = FU_ADD;
         uop.dest  = DEST_SP;
         {uop.s1, uop.imm} = instr[4:0];
      end else if (instr == 16'hBF00) begin
         uop = UOP_NOOP;
      end else if (is_push || is_pop) begin
         uop = UOP_NOOP;
      end else begin
         w_matched = 1'b0;
      end
`ifdef MICROCODE_SEQ_ILLEGAL_EN
      if (!w_matched) begin
         uop    = UOP_NOOP;
         uop.fu = FU_TRAP;
      end
      illegal = !w_matched;
`else
      if (!w_matched) begin
         uop = UOP_NOOP;
      end
`endif
   end

endmodule

`default_nettype wire

// File: rtl/microcode_sequencer.sv
// ============================================================================
//  Module      : microcode_sequencer
//  Description : Accepts Thumb instructions over valid/ready and issues
//                registered uops; PUSH/POP expand into SP adjust plus one
//                STR/LDR per listed register, with backpressure and flush.
//                Config macro MICROCODE_SEQ_ILLEGAL_EN enables trap uops and
//                uop_illegal_o for unmatched encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module microcode_sequencer
   import microcode_pkg::*;
#(
   parameter int INSTR_WIDTH_P = 16,
   parameter int UCODE_WIDTH_P = 18,
   parameter int RLIST_WIDTH_P = 8,
   parameter int MAX_UOPS_P    = 10
) (
   input  logic                     clk_i,
   input  logic                     reset_n_i,
   input  logic [INSTR_WIDTH_P-1:0] instr_i,
   input  logic                     instr_v_i,
   output logic                     instr_ready_o,
   input  logic                     flush_i,
   output logic [UCODE_WIDTH_P-1:0] uop_o,
   output logic [3:0]               uop_reg_o,
   output logic [3:0]               uop_off_o,
   output logic                     uop_last_o,
   output logic                     uop_illegal_o,
   output logic                     uop_v_o,
   input  logic                     uop_ready_i
);

   localparam int CNT_W = $clog2(MAX_UOPS_P);

   // Registered state and outputs
   seq_state_e               r_state;
   uop_t                     r_uop;
   logic [3:0]               r_reg;
   logic [3:0]               r_off;
   logic                     r_last;
   logic                     r_illegal;
   logic                     r_valid;
   logic [RLIST_WIDTH_P-1:0] r_mask;
   logic                     r_pend;
   logic                     r_push;
   logic [3:0]               r_off_cnt;
   logic [CNT_W-1:0]         r_n;

   // Decode of the offered instruction
   uop_t                     w_dec_uop;
   logic                     w_is_push;
   logic                     w_is_pop;
   logic                     w_dec_illegal;
   logic [RLIST_WIDTH_P-1:0] w_rlist;
   logic                     w_extra;
   logic [CNT_W-1:0]         w_n;

   logic w_ready;
   logic w_accept;
   logic w_hs;

   uop_decode_table #(
      .INSTR_WIDTH_P (INSTR_WIDTH_P)
   ) u_decode (
      .instr   (instr_i),
      .uop     (w_dec_uop),
      .is_push (w_is_push),
      .is_pop  (w_is_pop),
      .illegal (w_dec_illegal)
   );

   assign w_rlist  = instr_i[RLIST_WIDTH_P-1:0];
   assign w_extra  = instr_i[RLIST_WIDTH_P];
   assign w_ready  = !flush_i && (!r_valid || (uop_ready_i && r_last));
   assign w_accept = instr_v_i && w_ready;
   assign w_hs     = r_valid && uop_ready_i;

   // Transfer count n = popcount(rlist) + LR/PC bit
   always_comb begin
      w_n = CNT_W'(w_extra);
      for (int i = 0; i < RLIST_WIDTH_P; i++) begin
         w_n = w_n + CNT_W'(w_rlist[i]);
      end
   end

   // Step source: a freshly accepted POP starts from the instruction, otherwise
   // the sequence continues from the saved bit-scan state
   logic [RLIST_WIDTH_P-1:0] s_mask;
   logic                     s_pend;
   logic                     s_push;
   logic [3:0]               s_off;
   logic [CNT_W-1:0]         s_n;

   assign s_mask = w_accept ? w_rlist : r_mask;
   assign s_pend = w_accept ? w_extra : r_pend;
   assign s_push = w_accept ? 1'b0    : r_push;
   assign s_off  = w_accept ? 4'd0    : r_off_cnt;
   assign s_n    = w_accept ? w_n     : r_n;

   logic [3:0]               w_low_idx;
   uop_t                     w_st_uop;
   logic [3:0]               w_st_reg;
   logic [3:0]               w_st_off;
   logic                     w_st_last;
   logic [RLIST_WIDTH_P-1:0] w_st_mask;
   logic                     w_st_pend;
   logic                     w_st_mem;

   // Next uop of an expansion: lowest listed register, then LR/PC, then (POP) SP adjust
   always_comb begin
      w_low_idx = 4'd0;
      for (int i = RLIST_WIDTH_P - 1; i >= 0; i--) begin
         if (s_mask[i]) w_low_idx = 4'(i);
      end
      w_st_uop  = UOP_NOOP;
      w_st_reg  = 4'd0;
      w_st_off  = 4'd0;
      w_st_last = 1'b0;
      w_st_mask = s_mask;
      w_st_pend = s_pend;
      w_st_mem  = 1'b0;
      if ((|s_mask) || s_pend) begin
         w_st_mem = 1'b1;
         w_st_off = s_off;
         if (|s_mask) begin
            w_st_reg  = w_low_idx;
            w_st_mask = s_mask & (s_mask - RLIST_WIDTH_P'(1));
            w_st_last = s_push && (w_st_mask == '0) && !s_pend;
            w_st_uop.op = s_push ? OP_STR : OP_LDR;
         end else begin
            w_st_reg  = s_push ? REG_LR : REG_PC;
            w_st_pend = 1'b0;
            w_st_last = s_push;
            w_st_uop.op = s_push ? OP_STR : OP_BX;
         end
         w_st_uop.we   = !s_push;
         w_st_uop.fu   = FU_MEM;
         w_st_uop.dest = w_st_reg[1:0];
         w_st_uop.s1   = DEST_SP;
      end else begin
         w_st_uop  = sp_adjust_uop(1'b0, 5'(s_n));
         w_st_reg  = REG_SP;
         w_st_last = 1'b1;
      end
   end

   // Sequencer FSM with registered uop outputs; flush outranks accept and advance
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state   <= S_IDLE;
         r_uop     <= UOP_NOOP;
         r_reg     <= 4'd0;
         r_off     <= 4'd0;
         r_last    <= 1'b0;
         r_illegal <= 1'b0;
         r_valid   <= 1'b0;
         r_mask    <= '0;
         r_pend    <= 1'b0;
         r_push    <= 1'b0;
         r_off_cnt <= 4'd0;
         r_n       <= '0;
      end else if (flush_i) begin
         r_state   <= S_IDLE;
         r_uop     <= UOP_NOOP;
         r_reg     <= 4'd0;
         r_off     <= 4'd0;
         r_last    <= 1'b0;
         r_illegal <= 1'b0;
         r_valid   <= 1'b0;
         r_mask    <= '0;
         r_pend    <= 1'b0;
         r_off_cnt <= 4'd0;
      end else if (w_accept) begin
         r_valid   <= 1'b1;
         r_state   <= S_ISSUE;
         r_uop     <= w_dec_uop;
         r_reg     <= 4'd0;
         r_off     <= 4'd0;
         r_last    <= 1'b1;
         r_illegal <= 1'b0;
         r_mask    <= '0;
         r_pend    <= 1'b0;
         r_push    <= w_is_push;
         r_off_cnt <= 4'd0;
         r_n       <= w_n;
         if ((w_is_push || w_is_pop) && (w_n != '0)) begin
            r_state <= S_EXPAND;
            if (w_is_push) begin
               r_uop  <= sp_adjust_uop(1'b1, 5'(w_n));
               r_reg  <= REG_SP;
               r_last <= 1'b0;
               r_mask <= w_rlist;
               r_pend <= w_extra;
            end else begin
               r_uop     <= w_st_uop;
               r_reg     <= w_st_reg;
               r_off     <= w_st_off;
               r_last    <= w_st_last;
               r_mask    <= w_st_mask;
               r_pend    <= w_st_pend;
               r_off_cnt <= 4'd1;
            end
         end else if (!(w_is_push || w_is_pop)) begin
            // Empty-list PUSH/POP falls through as a plain NOOP
            r_illegal <= w_dec_illegal;
         end
      end else if (w_hs) begin
         if (r_last) begin
            r_state   <= S_IDLE;
            r_valid   <= 1'b0;
            r_uop     <= UOP_NOOP;
            r_reg     <= 4'd0;
            r_off     <= 4'd0;
            r_last    <= 1'b0;
            r_illegal <= 1'b0;
         end else if (r_state == S_EXPAND) begin
            r_uop  <= w_st_uop;
            r_reg  <= w_st_reg;
            r_off  <= w_st_off;
            r_last <= w_st_last;
            r_mask <= w_st_mask;
            r_pend <= w_st_pend;
            if (w_st_mem) r_off_cnt <= r_off_cnt + 4'd1;
         end
      end
   end

   assign instr_ready_o = w_ready;
   assign uop_o         = r_uop;
   assign uop_reg_o     = r_reg;
   assign uop_off_o     = r_off;
   assign uop_last_o    = r_last;
   assign uop_illegal_o = r_illegal;
   assign uop_v_o       = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_microcode_sequencer.sv
// ============================================================================
//  Module      : tb_microcode_sequencer
//  Description : Directed self-checking bench for microcode_sequencer with
//                hand-computed uop sequences. Honours MICROCODE_SEQ_ILLEGAL_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_microcode_sequencer;

   logic        clk;
   logic        rst_n;
   logic [15:0] instr;
   logic        instr_v;
   logic        instr_ready;
   logic        flush;
   logic [17:0] uop;
   logic [3:0]  uop_reg;
   logic [3:0]  uop_off;
   logic        uop_last;
   logic        uop_illegal;
   logic        uop_v;
   logic        uop_ready;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [17:0] u;
      logic [3:0]  rg;
      logic [3:0]  off;
      logic        last;
      logic        il;
   } exp_t;

   exp_t exp_q[$];

   microcode_sequencer dut (
      .clk_i         (clk),
      .reset_n_i     (rst_n),
      .instr_i       (instr),
      .instr_v_i     (instr_v),
      .instr_ready_o (instr_ready),
      .flush_i       (flush),
      .uop_o         (uop),
      .uop_reg_o     (uop_reg),
      .uop_off_o     (uop_off),
      .uop_last_o    (uop_last),
      .uop_illegal_o (uop_illegal),
      .uop_v_o       (uop_v),
      .uop_ready_i   (uop_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Field packing: WE, OP, FU, FLAGS, DEST, S1, IMM
   function automatic logic [17:0] mk(input logic we, input logic [2:0] op, input logic [2:0] fu,
                                      input logic [3:0] fl, input logic [1:0] d, input logic [1:0] s1,
                                      input logic [2:0] imm);
      return {we, op, fu, fl, d, s1, imm};
   endfunction

   function automatic exp_t ex(input logic [17:0] u, input logic [3:0] rg, input logic [3:0] off,
                               input logic last, input logic il);
      return '{u: u, rg: rg, off: off, last: last, il: il};
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%h expected=%h", tag, got, want);
      end
   endtask

   task automatic check_uop(input string tag, input exp_t e);
      check_eq({tag, "_v"},    32'(uop_v), 32'd1);
      check_eq({tag, "_uop"},  32'(uop), 32'(e.u));
      check_eq({tag, "_reg"},  32'(uop_reg), 32'(e.rg));
      check_eq({tag, "_off"},  32'(uop_off), 32'(e.off));
      check_eq({tag, "_last"}, 32'(uop_last), 32'(e.last));
      check_eq({tag, "_ill"},  32'(uop_illegal), 32'(e.il));
   endtask

   // Offer one instruction, then walk the expected uops; optional stall on one index
   task automatic run_seq(input string tag, input logic [15:0] ins, input int stall_at, input int stall_n);
      instr     = ins;
      instr_v   = 1'b1;
      uop_ready = 1'b1;
      @(negedge clk);
      check_eq({tag, "_accept_rdy"}, 32'(instr_ready), 32'd1);
      @(posedge clk); #1;
      instr_v = 1'b0;
      instr   = 16'h0000;
      for (int k = 0; k < exp_q.size(); k++) begin
         if (k == stall_at) begin
            uop_ready = 1'b0;
            instr     = 16'h4000;
            instr_v   = 1'b1;
            for (int s = 0; s < stall_n; s++) begin
               @(negedge clk);
               check_uop({tag, "_stall"}, exp_q[k]);
               check_eq({tag, "_stall_rdy"}, 32'(instr_ready), 32'd0);
               @(posedge clk); #1;
            end
            uop_ready = 1'b1;
            instr_v   = 1'b0;
            instr     = 16'h0000;
         end
         @(negedge clk);
         check_uop($sformatf("%s_u%0d", tag, k), exp_q[k]);
         check_eq($sformatf("%s_u%0d_rdy", tag, k), 32'(instr_ready), 32'(exp_q[k].last));
         @(posedge clk); #1;
      end
      @(negedge clk);
      check_eq({tag, "_idle_v"}, 32'(uop_v), 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [17:0] u_adds;
      logic [17:0] u_ands;
      u_adds = mk(1'b1, 3'b000, 3'd1, 4'b1111, 2'b00, 2'b01, 3'b010);
      u_ands = mk(1'b1, 3'b000, 3'd2, 4'b1100, 2'b00, 2'b00, 3'b000);

      rst_n = 1'b0; instr = 16'h0; instr_v = 1'b0; flush = 1'b0; uop_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_v",    32'(uop_v), 32'd0);
      check_eq("rst_uop",  32'(uop), 32'd0);
      check_eq("rst_last", 32'(uop_last), 32'd0);
      check_eq("rst_reg",  32'(uop_reg), 32'd0);
      check_eq("rst_off",  32'(uop_off), 32'd0);
      check_eq("rst_ill",  32'(uop_illegal), 32'd0);
      check_eq("rst_rdy",  32'(instr_ready), 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // ADDS then ANDS back to back with no bubble
      uop_ready = 1'b1; instr = 16'h1888; instr_v = 1'b1;
      @(negedge clk);
      check_eq("adds_rdy", 32'(instr_ready), 32'd1);
      @(posedge clk); #1;
      instr = 16'h4000;
      @(negedge clk);
      check_uop("adds", ex(u_adds, 4'd0, 4'd0, 1'b1, 1'b0));
      check_eq("b2b_rdy", 32'(instr_ready), 32'd1);
      @(posedge clk); #1;
      instr_v = 1'b0;
      @(negedge clk);
      check_uop("ands", ex(u_ands, 4'd0, 4'd0, 1'b1, 1'b0));
      @(posedge clk); #1;
      @(negedge clk);
      check_eq("single_idle_v", 32'(uop_v), 32'd0);
      @(posedge clk); #1;

      // PUSH {r0,r2,lr} with 3-cycle stall on the 2nd uop
      exp_q = {};
      exp_q.push_back(ex(mk(1'b1, 3'b001, 3'd1, 4'd0, 2'd3, 2'd0, 3'd3), 4'd13, 4'd0, 1'b0, 1'b0));
      exp_q.push_back(ex(mk(1'b0, 3'b001, 3'd3, 4'd0, 2'd0, 2'd3, 3'd0), 4'd0,  4'd0, 1'b0, 1'b0));
      exp_q.push_back(ex(mk(1'b0, 3'b001, 3'd3, 4'd0, 2'd2, 2'd3, 3'd0), 4'd2,  4'd1, 1'b0, 1'b0));
      exp_q.push_back(ex(mk(1'b0, 3'b001, 3'd3, 4'd0, 2'd2, 2'd3, 3'd0), 4'd14, 4'd2, 1'b1, 1'b0));
      run_seq("push", 16'hB505, 1, 3);

      // POP {r1,pc}
      exp_q = {};
      exp_q.push_back(ex(mk(1'b1, 3'b000, 3'd3, 4'd0, 2'd1, 2'd3, 3'd0), 4'd1,  4'd0, 1'b0, 1'b0));
      exp_q.push_back(ex(mk(1'b1, 3'b011, 3'd3, 4'd0, 2'd3, 2'd3, 3'd0), 4'd15, 4'd1, 1'b0, 1'b0));
      exp_q.push_back(ex(mk(1'b1, 3'b000, 3'd1, 4'd0, 2'd3, 2'd0, 3'd2), 4'd13, 4'd0, 1'b1, 1'b0));
      run_seq("pop", 16'hBD02, -1, 0);

      // Empty PUSH list: single NOOP
      exp_q = {};
      exp_q.push_back(ex(18'h0, 4'd0, 4'd0, 1'b1, 1'b0));
      run_seq("push_empty", 16'hB400, -1, 0);

      // Unmatched encoding
      exp_q = {};
`ifdef MICROCODE_SEQ_ILLEGAL_EN
      exp_q.push_back(ex(mk(1'b0, 3'b000, 3'd7, 4'd0, 2'd0, 2'd0, 3'd0), 4'd0, 4'd0, 1'b1, 1'b1));
`else
      exp_q.push_back(ex(18'h0, 4'd0, 4'd0, 1'b1, 1'b0));
`endif
      run_seq("illegal", 16'hDE00, -1, 0);

      // Flush during the 3rd POP uop, then ANDS issues normally
      uop_ready = 1'b1; instr = 16'hBD02; instr_v = 1'b1;
      @(posedge clk); #1;
      instr_v = 1'b0;
      @(negedge clk);
      check_eq("fl_u0_reg", 32'(uop_reg), 32'd1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      uop_ready = 1'b0; flush = 1'b1; instr = 16'h4000; instr_v = 1'b1;
      @(negedge clk);
      check_eq("fl_u2_reg", 32'(uop_reg), 32'd13);
      check_eq("fl_rdy",    32'(instr_ready), 32'd0);
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      check_eq("fl_after_v",   32'(uop_v), 32'd0);
      check_eq("fl_after_rdy", 32'(instr_ready), 32'd1);
      @(posedge clk); #1;
      instr_v = 1'b0; uop_ready = 1'b1;
      @(negedge clk);
      check_uop("fl_ands", ex(u_ands, 4'd0, 4'd0, 1'b1, 1'b0));
      @(posedge clk); #1;
      @(negedge clk);
      check_eq("fl_idle_v", 32'(uop_v), 32'd0);
      @(posedge clk); #1;

      // Reset during cycle 2 of a PUSH expansion
      instr = 16'hB505; instr_v = 1'b1;
      @(posedge clk); #1;
      instr_v = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check_eq("rmid_u1_reg", 32'(uop_reg), 32'd0);
      check_eq("rmid_u1_v",   32'(uop_v), 32'd1);
      rst_n = 1'b0;
      #1;
      check_eq("rmid_async_v", 32'(uop_v), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("rmid_rel_v",   32'(uop_v), 32'd0);
      check_eq("rmid_rel_rdy", 32'(instr_ready), 32'd1);
      check_eq("rmid_rel_uop", 32'(uop), 32'd0);
      @(posedge clk); #1;
      instr = 16'h1888; instr_v = 1'b1;
      @(posedge clk); #1;
      instr_v = 1'b0;
      @(negedge clk);
      check_uop("rmid_adds", ex(u_adds, 4'd0, 4'd0, 1'b1, 1'b0));
      @(posedge clk); #1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/microcode_sequencer.md
Name: microcode_sequencer

Overview:
- Parametrised successor to the single-cycle Thumb micro-op decode table.
- Accepts 16-bit Thumb instructions from fetch over a valid/ready handshake and emits registered micro-ops to the backend over a second valid/ready handshake.
- Single-micro-op instructions issue one uop.
- PUSH/POP are expanded into a multi-uop sequence: one STR/LDR per listed register plus an SP adjust, with backpressure and flush.

Parameters:
- INSTR_WIDTH_P, 16: fetched instruction width.
- UCODE_WIDTH_P, 18: uop width. Fields: WE1, OP3, FU3, FLAGS4, DEST2, S1 2, IMM/S2 3.
- RLIST_WIDTH_P, 8: PUSH/POP low-register list width.
- MAX_UOPS_P, 10: maximum uops per instruction (RLIST_WIDTH_P+2).

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- instr_i  in  INSTR_WIDTH_P  instruction from fetch
- instr_v_i  in  1  instruction valid
- instr_ready_o  out  1  sequencer can accept
- flush_i  in  1  synchronous kill of in-flight sequence
- uop_o  out  UCODE_WIDTH_P  micro-op
- uop_reg_o  out  4  architectural register for PUSH/POP uops, else 0
- uop_off_o  out  4  word offset for PUSH/POP memory uops, else 0
- uop_last_o  out  1  final uop of instruction
- uop_illegal_o  out  1  unrecognised encoding (see Optional Feature)
- uop_v_o  out  1  uop valid
- uop_ready_i  in  1  backend accepts uop

Behaviour:
- Clock and reset: one clock, clk_i. reset_n_i is asynchronous, active-low.
- Reset values: state IDLE, uop_v_o=0, all other outputs 0, counters 0.
- Accept: instr_ready_o = !flush_i && (!uop_v_o || (uop_ready_i && uop_last_o)). This is a combinational path from uop_ready_i, and it allows back-to-back single uops.
- Latency: accept at cycle N drives uop_v_o=1 with the first uop at N+1.
- Output hold: while uop_v_o && !uop_ready_i, all uop outputs hold stable.
- Output advance: the sequence advances only on a uop handshake.
- FSM states:
  - IDLE: nothing valid.
  - ISSUE: single uop held.
  - EXPAND: multi-uop in progress.
- FSM transitions:
  - IDLE/ISSUE → ISSUE on accepting a non-PUSH/POP instruction.
  - IDLE/ISSUE → EXPAND on accepting PUSH/POP.
  - EXPAND → EXPAND on a handshake while uops remain.
  - Any state → IDLE on handshake of the last uop with no new accept.
- PUSH (1011010 R rlist):
  - n = popcount(rlist)+R.
  - uop0: SP -= 4n (FU1 OP001, DEST=SP).
  - Then one STR per set bit, ascending r0..r7, with uop_off_o = 0..n-1.
  - If R=1, STR r14 comes last. The final STR carries uop_last_o.
- POP (1011110 P rlist):
  - One LDR per set bit, ascending.
  - If P=1, LDR r15 follows, with WE and BX-style OP 011.
  - Final uop: SP += 4n, with uop_last_o.
- Empty list (n=0): single NOOP uop with uop_last_o=1.
- Counter: a bit-scan mask register clears the lowest set bit each handshake. The offset counter is 4-bit and increments per memory uop. It never exceeds n-1 (max 8).
- Flush: flush_i takes priority over everything.
  - Next cycle: uop_v_o=0, state IDLE, mask cleared.
  - No accept occurs in the flush cycle.
- Reset mid-EXPAND: immediate return to reset values. The partial sequence is discarded.

Optional Feature:
- Macro: MICROCODE_SEQ_ILLEGAL_EN.
- Defined: encodings matching no table entry issue one uop with FU=3'd7 (trap), WE=0 and uop_last_o=1, and assert uop_illegal_o with that uop.
- Undefined: unmatched encodings issue NOOP (all zero) and uop_illegal_o is tied 0.

Decomposition:
- Package microcode_pkg:
  - uop_t packed struct with the field widths above.
  - FU enum: MOV=0, ADD=1, LOGIC=2, MEM=3, BR=4, TRAP=7.
  - SP/LR/PC register index constants.
  - UOP_NOOP constant.
  - seq_state_e enum.
- Sub-module uop_decode_table: combinational instruction → uop_t lookup for single-uop instructions, with a PUSH/POP detect output. The sequencer instantiates it once.

Test Plan:
- Reset: assert reset_n_i low during cycle 2 of a PUSH expansion → uop_v_o=0 and instr_ready_o=1 immediately after release.
- Single uop: ADDS 0x1888 accepted at N → at N+1 uop FU=1, FLAGS=1111, WE=1, uop_last_o=1. Second instruction is accepted in the same cycle as the handshake, with no bubble.
- PUSH {r0,r2,lr}, 0xB505 → 4 uops:
  - SP-=12
  - STR r0 off0
  - STR r2 off1
  - STR r14 off2, last=1
- POP {r1,pc}, 0xBD02 → 3 uops:
  - LDR r1 off0
  - LDR r15 off1, OP=011
  - SP+=8, last=1
- Backpressure: hold uop_ready_i=0 for 3 cycles on the 2nd PUSH uop → outputs stable, no uop skipped, instr_ready_o=0 throughout.
- Flush and illegal:
  - flush_i during the 3rd POP uop → uop_v_o=0 next cycle, and a following ANDS 0x4000 issues normally.
  - With MICROCODE_SEQ_ILLEGAL_EN, 0xDE00 → FU=7, uop_illegal_o=1.
